// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK-flop register bank between N requesters.
// Each edge, one eligible requester's LOAD/SET/CLEAR/TOGGLE is applied and a grant pulse is returned.
module jk_bank_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8,
  parameter logic [W-1:0] INIT = '0,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [2*N-1:0]     op,
  input  logic [N*W-1:0]     data,
  output logic [W-1:0]       q,
  output logic [N-1:0]       gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [CNT_W-1:0]   op_count
);

  logic [ID_W-1:0] ptr;
  logic [N-1:0]    eligible;
  logic [N-1:0]    sel;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] ptr_nxt;
  logic [W-1:0]    d;
  logic [1:0]      opsel;
  logic [W-1:0]    j;
  logic [W-1:0]    k;
  logic [W-1:0]    q_nxt;

  // Winner search: first eligible index at or above ptr, else first one below ptr.
  always_comb begin
    eligible = req & ~gnt;
    sel      = '0;
    found    = 1'b0;
    win      = '0;
    ptr_nxt  = ptr;
    d        = '0;
    opsel    = 2'b00;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && eligible[i] && i >= int'(ptr)) begin
        found   = 1'b1;
        win     = ID_W'(i);
        ptr_nxt = (i == int'(N) - 1) ? '0 : ID_W'(i + 1);
        d       = data[W*i +: W];
        opsel   = op[2*i +: 2];
        sel[i]  = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && eligible[i] && i < int'(ptr)) begin
        found   = 1'b1;
        win     = ID_W'(i);
        ptr_nxt = (i == int'(N) - 1) ? '0 : ID_W'(i + 1);
        d       = data[W*i +: W];
        opsel   = op[2*i +: 2];
        sel[i]  = 1'b1;
      end
    end
  end

  // J/K drive for the winning operation, then the JK characteristic equation.
  always_comb begin
    j = '0;
    k = '0;
    case (opsel)
      2'b00: begin j = d;  k = ~d; end
      2'b01: begin j = d;  k = '0; end
      2'b10: begin j = '0; k = d;  end
      default: begin j = d; k = d; end
    endcase
    q_nxt = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q        <= INIT;
      gnt      <= '0;
      gnt_id   <= '0;
      op_count <= '0;
      ptr      <= '0;
    end else begin
      gnt <= sel;
      if (found) begin
        q        <= q_nxt;
        gnt_id   <= win;
        ptr      <= ptr_nxt;
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter (N=2, W=4, CNT_W=3): a behavioural model pushes
// expected outputs per driven edge; they are popped and compared one cycle later.
module tb_jk_bank_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [W-1:0]     q;
    logic [N-1:0]     gnt;
    logic             gnt_id;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [N*W-1:0]   data;
  logic [W-1:0]     q;
  logic [N-1:0]     gnt;
  logic             gnt_id;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  logic [W-1:0]     m_q;
  logic [N-1:0]     m_gnt;
  logic             m_id;
  int               m_ptr;
  logic [CNT_W-1:0] m_cnt;

  jk_bank_arbiter #(.N(N), .W(W), .CNT_W(CNT_W), .INIT(4'b0000)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data),
    .q(q), .gnt(gnt), .gnt_id(gnt_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of one clock edge; returns the expected post-edge outputs.
  function automatic exp_t model(input logic r, input logic [N-1:0] rq,
                                 input logic [2*N-1:0] o, input logic [N*W-1:0] dt);
    exp_t e;
    int w;
    logic [N-1:0] el;
    logic [W-1:0] dd;
    if (!r) begin
      m_q = '0; m_gnt = '0; m_id = 1'b0; m_ptr = 0; m_cnt = '0;
    end else begin
      el = rq & ~m_gnt;
      w = -1;
      for (int s = 0; s < int'(N); s++)
        if (w < 0 && el[(m_ptr + s) % N]) w = (m_ptr + s) % N;
      m_gnt = '0;
      if (w >= 0) begin
        dd = dt[W*w +: W];
        case (o[2*w +: 2])
          2'b00: m_q = dd;
          2'b01: m_q = m_q | dd;
          2'b10: m_q = m_q & ~dd;
          default: m_q = m_q ^ dd;
        endcase
        m_gnt[w] = 1'b1;
        m_id  = w[0];
        m_ptr = (w + 1) % N;
        m_cnt = m_cnt + 3'd1;
      end
    end
    e.q = m_q; e.gnt = m_gnt; e.gnt_id = m_id; e.cnt = m_cnt;
    return e;
  endfunction

  // Drive one edge of stimulus, push the model's prediction, then pop and compare.
  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic [2*N-1:0] o, input logic [N*W-1:0] dt);
    exp_t e;
    rst = r; req = rq; op = o; data = dt;
    exp_q.push_back(model(r, rq, o, dt));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_q", 32'(q), 32'(e.q));
      check("sb_gnt", 32'(gnt), 32'(e.gnt));
      check("sb_gnt_id", 32'(gnt_id), 32'(e.gnt_id));
      check("sb_op_count", 32'(op_count), 32'(e.cnt));
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; op = '0; data = '0;
    m_q = '0; m_gnt = '0; m_id = 1'b0; m_ptr = 0; m_cnt = '0;

    // Reset with both requests present
    step(1'b0, 2'b11, 4'b0000, 8'h00);
    step(1'b0, 2'b11, 4'b0000, 8'h00);
    check("rst_q", 32'(q), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_cnt", 32'(op_count), 32'h0);

    // LOAD 1010 by requester 0
    step(1'b1, 2'b01, 4'b0000, 8'h0A);
    check("load_q", 32'(q), 32'hA);
    check("load_gnt", 32'(gnt), 32'h1);
    check("load_cnt", 32'(op_count), 32'h1);

    // SET 0101 (req1), CLEAR 0011 (req0), TOGGLE 1001 (req1)
    step(1'b1, 2'b10, 4'b0100, 8'h50);
    check("set_q", 32'(q), 32'hF);
    step(1'b1, 2'b01, 4'b0010, 8'h03);
    check("clear_q", 32'(q), 32'hC);
    step(1'b1, 2'b10, 4'b1100, 8'h90);
    check("toggle_q", 32'(q), 32'h5);

    // Idle then contention from ptr=0
    step(1'b1, 2'b00, 4'b0000, 8'h00);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_q_hold", 32'(q), 32'h5);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11, 4'b1111, 8'h00);
      check("cont_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_id", 32'(gnt_id), 32'(i % 2));
    end

    // Self-mask: lone requester gets every other edge
    step(1'b0, 2'b00, 4'b0000, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b01, 4'b0011, 8'h01);
      check("mask_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    check("mask_cnt", 32'(op_count), 32'h3);

    // Reset mid-op, then LOAD applied on release
    step(1'b0, 2'b01, 4'b0000, 8'h0F);
    check("rmid_q", 32'(q), 32'h0);
    check("rmid_gnt", 32'(gnt), 32'h0);
    check("rmid_cnt", 32'(op_count), 32'h0);
    step(1'b1, 2'b01, 4'b0000, 8'h0F);
    check("rrel_q", 32'(q), 32'hF);
    check("rrel_gnt", 32'(gnt), 32'h1);

    // Counter wrap: 8 grants -> 0, 9th -> 1
    step(1'b0, 2'b00, 4'b0000, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 2'b11, 4'b1111, 8'h11);
      if (i == 7) check("wrap_cnt8", 32'(op_count), 32'h0);
    end
    check("wrap_cnt9", 32'(op_count), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) != 0), 2'($urandom), 4'($urandom), 8'($urandom));

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
